// File: rtl/m_read_responder.sv
// m_read_responder
// Read-side responder for the CPU's 12-bit memory map.
//   0x000-0x400 instruction ROM, 0x401-0x44B MMR block, 0x44C-0xFFF stack RAM.
// A request is accepted only while idle. The responder decodes the region, drives
// the matching read port, waits for the fixed latency or the MMR handshake, and
// returns one word with a single-cycle rd_valid.
// Optional feature: define MMR_TIMEOUT_EN to bound the MMR wait to TIMEOUT cycles.
// A timed-out response returns rd_data=0 with rd_err=1.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no transaction, ready to accept rd_req
// WAIT_MEM | ROM or stack read in flight, counting down the latency
// WAIT_MMR | MMR read issued, waiting for mmr_ack (or timeout)
// RESP     | rd_valid asserted for one cycle with the captured word
module m_read_responder #(
    parameter int DATA_W  = 16,
    parameter int ROM_LAT = 1,
    parameter int STK_LAT = 1,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [11:0]       rd_addr,
    output logic              busy,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    output logic [1:0]        sel,
    output logic [11:0]       rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [11:0]       stk_addr,
    input  logic [DATA_W-1:0] stk_data,
    output logic [6:0]        mmr_addr,
    output logic              mmr_rd,
    input  logic              mmr_ack,
    input  logic [DATA_W-1:0] mmr_data
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WAIT_MMR = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam logic [1:0] SEL_ROM = 2'd0;
    localparam logic [1:0] SEL_MMR = 2'd1;
    localparam logic [1:0] SEL_STK = 2'd2;

    // One down-counter serves both the memory latency and the MMR timeout.
    localparam int MAX_LAT = (ROM_LAT > STK_LAT) ? ROM_LAT : STK_LAT;
    localparam int MAX_CNT = (MAX_LAT > TIMEOUT) ? MAX_LAT : TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          sel_q, sel_d;
    logic [11:0]         rom_addr_q, rom_addr_d;
    logic [11:0]         stk_addr_q, stk_addr_d;
    logic [6:0]          mmr_addr_q, mmr_addr_d;
    logic                mmr_rd_q, mmr_rd_d;
    logic [DATA_W-1:0]   data_q, data_d;
`ifdef MMR_TIMEOUT_EN
    logic                err_q, err_d;
`endif

    logic [1:0]          req_sel;
    logic [11:0]         stk_off;
    logic [6:0]          mmr_off;

    // Region decode and offsets of the incoming request address.
    always_comb begin
        if (rd_addr <= 12'h400) begin
            req_sel = SEL_ROM;
        end else if (rd_addr <= 12'h44B) begin
            req_sel = SEL_MMR;
        end else begin
            req_sel = SEL_STK;
        end
        stk_off = rd_addr - 12'h44C;
        // Low 7 bits of (rd_addr - 0x401); 0x401 has 0x01 in its low 7 bits.
        mmr_off = rd_addr[6:0] - 7'h01;
    end

    // Next-state logic and register updates for the read transaction.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        rom_addr_d = rom_addr_q;
        stk_addr_d = stk_addr_q;
        mmr_addr_d = mmr_addr_q;
        mmr_rd_d   = 1'b0;
        data_d     = data_q;
`ifdef MMR_TIMEOUT_EN
        err_d      = err_q;
`endif

        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    sel_d      = req_sel;
                    rom_addr_d = rd_addr;
                    stk_addr_d = stk_off;
                    mmr_addr_d = mmr_off;
                    if (req_sel == SEL_MMR) begin
                        state_d  = WAIT_MMR;
                        mmr_rd_d = 1'b1;
                        cnt_d    = CNT_W'(TIMEOUT - 1);
                    end else begin
                        state_d = WAIT_MEM;
                        cnt_d   = (req_sel == SEL_ROM) ? CNT_W'(ROM_LAT) : CNT_W'(STK_LAT);
                    end
                end
            end

            WAIT_MEM: begin
                // Counter loaded with LAT gives LAT+1 wait cycles.
                if (cnt_q == '0) begin
                    data_d  = (sel_q == SEL_ROM) ? rom_data : stk_data;
`ifdef MMR_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            WAIT_MMR: begin
                if (mmr_ack) begin
                    data_d  = mmr_data;
`ifdef MMR_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = RESP;
`ifdef MMR_TIMEOUT_EN
                end else if (cnt_q == '0) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
`endif
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_q      <= '0;
            rom_addr_q <= '0;
            stk_addr_q <= '0;
            mmr_addr_q <= '0;
            mmr_rd_q   <= 1'b0;
            data_q     <= '0;
`ifdef MMR_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            rom_addr_q <= rom_addr_d;
            stk_addr_q <= stk_addr_d;
            mmr_addr_q <= mmr_addr_d;
            mmr_rd_q   <= mmr_rd_d;
            data_q     <= data_d;
`ifdef MMR_TIMEOUT_EN
            err_q      <= err_d;
`endif
        end
    end

    assign busy     = (state_q != IDLE);
    assign rd_valid = (state_q == RESP);
    assign rd_data  = data_q;
`ifdef MMR_TIMEOUT_EN
    assign rd_err   = rd_valid & err_q;
`else
    assign rd_err   = 1'b0;
`endif
    assign sel      = sel_q;
    assign rom_addr = rom_addr_q;
    assign stk_addr = stk_addr_q;
    assign mmr_addr = mmr_addr_q;
    assign mmr_rd   = mmr_rd_q;

endmodule
